// File: rtl/pdm_mic_capture.sv
// PDM microphone front end: mic clock divider, bit capture and boxcar decimation to signed PCM.
// Optional clock gating input is enabled by defining MIC_CLK_GATE_EN.
module pdm_mic_capture #(
    parameter int CLK_DIV = 20,
    parameter int DECIM   = 64,
    parameter int OUT_W   = 16,
    parameter int LRSEL   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    micro_data,
    output logic                    micro_clk,
    output logic                    lrsel,
    output logic                    anout,
    output logic signed [OUT_W-1:0] pcm_data,
    output logic                    pcm_valid,
    input  logic                    pcm_ready,
    output logic                    overrun
`ifdef MIC_CLK_GATE_EN
    ,
    input  logic                    enable
`endif
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DECIM);
    localparam int ACC_W = BIT_W + 1;

    logic [CNT_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [ACC_W-1:0]        ones;
    logic [ACC_W-1:0]        ones_total;
    logic                    sync_p0;
    logic                    sync_p1;
    logic                    run;
    logic                    div_wrap;
    logic                    sample_en;
    logic                    last_bit;
    logic                    vld_p2;
    logic signed [OUT_W-1:0] word_p2;

    // Boxcar result: 2*ones - DECIM, range -DECIM..+DECIM
    function automatic logic signed [OUT_W-1:0] to_pcm(input logic [ACC_W-1:0] n);
        logic signed [OUT_W-1:0] w;
        w = signed'(OUT_W'(n));
        return (w <<< 1) - signed'(OUT_W'(DECIM));
    endfunction

`ifdef MIC_CLK_GATE_EN
    assign run = enable;
`else
    assign run = 1'b1;
`endif

    assign lrsel      = (LRSEL != 0);
    assign div_wrap   = (div_cnt == CNT_W'(CLK_DIV - 1));
    assign sample_en  = run && div_wrap && (micro_clk == (LRSEL != 0));
    assign last_bit   = (bit_cnt == BIT_W'(DECIM - 1));
    assign ones_total = ones + ACC_W'(sync_p1);
    assign vld_p2     = sample_en && last_bit;
    assign word_p2    = to_pcm(ones_total);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            micro_clk <= 1'b0;
        end else if (!run) begin
            div_cnt   <= '0;
            micro_clk <= 1'b0;
        end else if (div_wrap) begin
            div_cnt   <= '0;
            micro_clk <= ~micro_clk;
        end else begin
            div_cnt   <= div_cnt + CNT_W'(1);
        end
    end

    // Stage p0/p1: two-flop synchroniser for the asynchronous PDM bit
    always_ff @(posedge clk) begin
        sync_p0 <= micro_data;
        sync_p1 <= sync_p0;
    end

    // Stage p2: capture on the selected mic clock edge and accumulate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anout   <= 1'b0;
            bit_cnt <= '0;
            ones    <= '0;
        end else if (!run) begin
            bit_cnt <= '0;
            ones    <= '0;
        end else if (sample_en) begin
            anout <= sync_p1;
            if (last_bit) begin
                bit_cnt <= '0;
                ones    <= '0;
            end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                ones    <= ones_total;
            end
        end
    end

    // Stage p3: output word register and handshake; a full slot drops new words
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (vld_p2) begin
            if (!pcm_valid || pcm_ready) begin
                pcm_data  <= word_p2;
                pcm_valid <= 1'b1;
            end else begin
                overrun   <= 1'b1;
            end
        end else if (pcm_valid && pcm_ready) begin
            pcm_valid <= 1'b0;
        end
    end

endmodule

// File: doc/pdm_mic_capture.md
# pdm_mic_capture

Parametrised PDM microphone front end for the Nexys4DDR on-board MEMS microphone. It generates the microphone clock from the 100 MHz system clock and samples the PDM bit on a selectable edge. The raw bit is forwarded for direct PWM playback, and the bit stream is decimated into signed PCM words behind a valid/ready handshake. It replaces the fixed-rate pass-through capture path and feeds the recorder/buffer logic downstream.

## Interface
Parameters:
- CLK_DIV, 20: system-clock cycles per micro_clk half-period (≥4); 20 gives 2.5 MHz
- DECIM, 64: PDM bits per PCM word; power of two, ≥2
- OUT_W, 16: PCM width; must satisfy log2(DECIM)+2 ≤ OUT_W
- LRSEL, 0: value driven on lrsel; 0 samples on micro_clk rising edge, 1 on falling edge

Ports:
- clk  in  1  100 MHz system clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- micro_data  in  1  PDM data from microphone (asynchronous)
- micro_clk  out  1  microphone clock
- lrsel  out  1  constant LRSEL
- anout  out  1  last sampled PDM bit (PWM audio out)
- pcm_data  out  OUT_W  signed PCM word, two's complement
- pcm_valid  out  1  pcm_data holds an unconsumed word
- pcm_ready  in  1  consumer accepts word when high with pcm_valid
- overrun  out  1  sticky: a completed word was dropped
- enable  in  1  present only with MIC_CLK_GATE_EN

## Operation
- Reset values: micro_clk=0, anout=0, pcm_data=0, pcm_valid=0, overrun=0. The divider counter, bit counter and ones accumulator are all 0.
- Divider: the counter runs 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and micro_clk toggles. The first rising edge occurs CLK_DIV cycles after reset release.
- Synchroniser: micro_data passes through a 2-flop synchroniser before use.
- Sampling: sample_en is asserted in the cycle where the counter is CLK_DIV-1 and micro_clk is about to make the selected transition (0→1 for LRSEL=0, 1→0 for LRSEL=1). In that cycle the synchronised bit is registered into anout.
- Decimation (boxcar):
  - Each sample_en adds the bit to a ones accumulator, width log2(DECIM)+1, and increments the bit counter.
  - On the DECIM-th bit, the word is computed as 2·ones − DECIM, sign-extended to OUT_W. The range is −DECIM..+DECIM.
  - The accumulator and bit counter then restart from 0, with the current bit included in the finished word.
- Output handshake, on word completion:
  - If pcm_valid=0, or pcm_valid&pcm_ready in the same cycle: load pcm_data, pcm_valid=1.
  - If pcm_valid&!pcm_ready: keep the old word, drop the new one, set overrun=1.
- pcm_valid&pcm_ready with no new word: pcm_valid←0; pcm_data holds its value.
- overrun is cleared only by reset.
- Reset mid-frame: the partial accumulation is discarded and micro_clk is forced low immediately (asynchronously). After release, the sequence restarts exactly as after power-up.

## Timing
- micro_clk period = 2·CLK_DIV cycles, duty 50%.
- anout updates 1 cycle after sample_en. Input-to-anout latency is 3 cycles (2 synchroniser + 1 capture).
- pcm_valid rises 1 cycle after the sample_en carrying the DECIM-th bit.
- PCM rate = 100 MHz/(2·CLK_DIV·DECIM); the defaults give 39.0625 kHz.
- pcm_ready has no combinational path to any output.

## Configuration
- MIC_CLK_GATE_EN defined: adds the enable input.
  - enable=0: micro_clk is held 0, the divider, bit counter and accumulator are cleared, and no sample_en occurs. pcm_valid/pcm_data still complete their handshake normally.
  - enable 0→1: behaves like reset release for the capture path; the first rising edge comes CLK_DIV cycles later.
- MIC_CLK_GATE_EN undefined: no enable port; the clock and capture path run freely from reset release.

## Test plan
- Defaults, micro_data=1 constant → micro_clk first rises at cycle 20, period 40 cycles; first pcm_data=0x0040 with pcm_valid after 64 sample edges.
- micro_data=0 constant, pcm_ready=1 → every word is 0xFFC0; pcm_valid pulses 1 cycle per 2560 cycles; overrun stays 0.
- micro_data alternating 1/0 per sample edge → pcm_data=0x0000; anout toggles every 40 cycles with 3-cycle lag.
- pcm_ready=0 throughout → the first word is held and pcm_valid stays 1. The second completion sets overrun=1 and pcm_data keeps the first word. Raising pcm_ready then clears pcm_valid the next cycle.
- Assert reset at bit 30 of a frame → outputs return to reset values at once; after release the next word reflects only the 64 post-reset bits.
- LRSEL=1 → lrsel=1; sample_en aligns to the falling micro_clk edges (cycle 40, 80, …).
- With MIC_CLK_GATE_EN: enable=0 for 5000 cycles → micro_clk stays 0 and no pcm_valid. Then enable=1 → micro_clk first rises 20 cycles later.
